// File: rtl/stopwatch_lap_cu.sv
// Stopwatch control unit: run/stop/clear/split FSM with an on-chip lap buffer.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_STOP  | counter halted, live display
// ST_RUN   | counter running, live display
// ST_SPLIT | counter running, display frozen on the last captured lap
// ST_CLEAR | one-cycle counter clear, lap buffer already emptied
module stopwatch_lap_cu #(
    parameter int TIME_W    = 24,
    parameter int LAP_DEPTH = 8,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_run,
    input  logic                           i_stop,
    input  logic                           i_clear,
    input  logic                           i_lap,
    input  logic [TIME_W-1:0]              i_time,
    input  logic [$clog2(LAP_DEPTH)-1:0]   i_rd_idx,
    output logic                           o_run,
    output logic                           o_clear,
    output logic                           o_freeze,
    output logic [TIME_W-1:0]              o_hold_time,
    output logic [$clog2(LAP_DEPTH+1)-1:0] o_lap_cnt,
    output logic                           o_lap_full,
    output logic                           o_lap_ovf,
    output logic [TIME_W-1:0]              o_rd_data
);

    localparam int IDX_W = $clog2(LAP_DEPTH);
    localparam int CNT_W = $clog2(LAP_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(LAP_DEPTH);
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(LAP_DEPTH - 1);
    localparam logic [IDX_W:0]   SUM_DEPTH = (IDX_W + 1)'(LAP_DEPTH);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SPLIT = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              capture;
    logic              wr_en;
    logic [IDX_W-1:0]  wptr;
    logic [IDX_W-1:0]  wptr_nxt;
    logic [IDX_W:0]    rd_sum;
    logic [IDX_W:0]    rd_wrap;
    logic [IDX_W-1:0]  rd_addr;
    logic              rd_hit;
    logic [TIME_W-1:0] mem [LAP_DEPTH];

    assign o_lap_full = (o_lap_cnt == DEPTH_C);

    // Next-state and capture decode; earlier branches win on simultaneous commands.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            ST_STOP: begin
                if (i_run)        state_nxt = ST_RUN;
                else if (i_clear) state_nxt = ST_CLEAR;
            end
            ST_RUN: begin
                if (i_stop) begin
                    state_nxt = ST_STOP;
                end else if (i_lap) begin
                    state_nxt = ST_SPLIT;
                    capture   = 1'b1;
                end
            end
            ST_SPLIT: begin
                if (i_stop)      state_nxt = ST_STOP;
                else if (i_run)  state_nxt = ST_RUN;
                else if (i_lap)  capture   = 1'b1;
            end
            ST_CLEAR: state_nxt = ST_STOP;
            default:  state_nxt = ST_STOP;
        endcase
    end

    // Write side: a full buffer only accepts writes in overwrite mode.
    assign wr_en    = capture && !rst && (!o_lap_full || OVERWRITE);
    assign wptr_nxt = (wptr == LAST_PTR) ? '0 : wptr + IDX_W'(1);

    // Read address: in overwrite mode a full buffer's oldest entry sits at wptr.
    assign rd_sum  = {1'b0, wptr} + {1'b0, i_rd_idx};
    assign rd_wrap = (rd_sum >= SUM_DEPTH) ? rd_sum - SUM_DEPTH : rd_sum;
    assign rd_addr = (o_lap_full && OVERWRITE) ? rd_wrap[IDX_W-1:0] : i_rd_idx;
    assign rd_hit  = (CNT_W'(i_rd_idx) < o_lap_cnt);

    // State register, registered control outputs and lap bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_STOP;
            o_run       <= 1'b0;
            o_freeze    <= 1'b0;
            o_clear     <= 1'b0;
            o_hold_time <= '0;
            o_lap_cnt   <= '0;
            o_lap_ovf   <= 1'b0;
            wptr        <= '0;
        end else begin
            state    <= state_nxt;
            o_run    <= (state_nxt == ST_RUN) || (state_nxt == ST_SPLIT);
            o_freeze <= (state_nxt == ST_SPLIT);
            o_clear  <= (state_nxt == ST_CLEAR);
            if (state == ST_STOP && state_nxt == ST_CLEAR) begin
                o_hold_time <= '0;
                o_lap_cnt   <= '0;
                o_lap_ovf   <= 1'b0;
                wptr        <= '0;
            end else if (capture) begin
                o_hold_time <= i_time;
                if (!o_lap_full) begin
                    wptr      <= wptr_nxt;
                    o_lap_cnt <= o_lap_cnt + CNT_W'(1);
                end else if (OVERWRITE) begin
                    wptr <= wptr_nxt;
                end else begin
                    o_lap_ovf <= 1'b1;
                end
            end
        end
    end

    // Lap storage; contents are left unreset and hidden behind o_lap_cnt.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= i_time;
    end

    // Registered readback from pre-edge count, pointer and memory.
    always_ff @(posedge clk) begin
        if (rst)         o_rd_data <= '0;
        else if (rd_hit) o_rd_data <= mem[rd_addr];
        else             o_rd_data <= '0;
    end

endmodule

// File: tb/tb_stopwatch_lap_cu.sv
module tb_stopwatch_lap_cu;

    localparam int TW = 24;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0, i_run = 1'b0, i_stop = 1'b0, i_clear = 1'b0, i_lap = 1'b0;
    logic [TW-1:0] i_time = '0;
    logic [1:0] i_rd_idx = '0;

    logic a_run, a_clear, a_freeze, a_full, a_ovf;
    logic [TW-1:0] a_hold, a_rd;
    logic [2:0] a_cnt;
    logic b_run, b_clear, b_freeze, b_full, b_ovf;
    logic [TW-1:0] b_hold, b_rd;
    logic [2:0] b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_lap_cu #(.TIME_W(TW), .LAP_DEPTH(DEPTH), .OVERWRITE(1'b0)) dut_drop (
        .clk(clk), .rst(rst), .i_run(i_run), .i_stop(i_stop), .i_clear(i_clear),
        .i_lap(i_lap), .i_time(i_time), .i_rd_idx(i_rd_idx),
        .o_run(a_run), .o_clear(a_clear), .o_freeze(a_freeze), .o_hold_time(a_hold),
        .o_lap_cnt(a_cnt), .o_lap_full(a_full), .o_lap_ovf(a_ovf), .o_rd_data(a_rd));

    stopwatch_lap_cu #(.TIME_W(TW), .LAP_DEPTH(DEPTH), .OVERWRITE(1'b1)) dut_ovw (
        .clk(clk), .rst(rst), .i_run(i_run), .i_stop(i_stop), .i_clear(i_clear),
        .i_lap(i_lap), .i_time(i_time), .i_rd_idx(i_rd_idx),
        .o_run(b_run), .o_clear(b_clear), .o_freeze(b_freeze), .o_hold_time(b_hold),
        .o_lap_cnt(b_cnt), .o_lap_full(b_full), .o_lap_ovf(b_ovf), .o_rd_data(b_rd));

    // Reference model: mode plus one lap queue per buffer policy.
    localparam int M_STOP = 0, M_RUN = 1, M_SPLIT = 2, M_CLEAR = 3;
    int m_mode = M_STOP;
    int m_hold = 0;
    bit m_ovf_drop = 0;
    int laps_drop[$];
    int laps_ovw[$];
    int e_rd_drop = 0, e_rd_ovw = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_capture();
        m_hold = int'(i_time);
        if (laps_drop.size() < DEPTH) laps_drop.push_back(int'(i_time));
        else m_ovf_drop = 1;
        if (laps_ovw.size() == DEPTH) void'(laps_ovw.pop_front());
        laps_ovw.push_back(int'(i_time));
    endtask

    task automatic model_step();
        int idx;
        idx = int'(i_rd_idx);
        e_rd_drop = (idx < laps_drop.size()) ? laps_drop[idx] : 0;
        e_rd_ovw  = (idx < laps_ovw.size())  ? laps_ovw[idx]  : 0;
        if (rst) begin
            m_mode = M_STOP; m_hold = 0; m_ovf_drop = 0;
            laps_drop.delete(); laps_ovw.delete();
            e_rd_drop = 0; e_rd_ovw = 0;
        end else begin
            case (m_mode)
                M_STOP:
                    if (i_run) m_mode = M_RUN;
                    else if (i_clear) begin
                        m_mode = M_CLEAR; m_hold = 0; m_ovf_drop = 0;
                        laps_drop.delete(); laps_ovw.delete();
                    end
                M_RUN:
                    if (i_stop) m_mode = M_STOP;
                    else if (i_lap) begin m_mode = M_SPLIT; model_capture(); end
                M_SPLIT:
                    if (i_stop) m_mode = M_STOP;
                    else if (i_run) m_mode = M_RUN;
                    else if (i_lap) model_capture();
                default: m_mode = M_STOP;
            endcase
        end
    endtask

    task automatic model_check();
        int n;
        n = laps_drop.size();
        chk("run",       {31'd0, a_run},    {31'd0, (m_mode == M_RUN || m_mode == M_SPLIT)});
        chk("freeze",    {31'd0, a_freeze}, {31'd0, (m_mode == M_SPLIT)});
        chk("clear",     {31'd0, a_clear},  {31'd0, (m_mode == M_CLEAR)});
        chk("hold",      32'(a_hold),       32'(m_hold));
        chk("cnt",       32'(a_cnt),        32'(n));
        chk("full",      {31'd0, a_full},   {31'd0, (n == DEPTH)});
        chk("ovf",       {31'd0, a_ovf},    {31'd0, m_ovf_drop});
        chk("rd",        32'(a_rd),         32'(e_rd_drop));
        chk("ow_run",    {31'd0, b_run},    {31'd0, (m_mode == M_RUN || m_mode == M_SPLIT)});
        chk("ow_freeze", {31'd0, b_freeze}, {31'd0, (m_mode == M_SPLIT)});
        chk("ow_clear",  {31'd0, b_clear},  {31'd0, (m_mode == M_CLEAR)});
        chk("ow_hold",   32'(b_hold),       32'(m_hold));
        chk("ow_cnt",    32'(b_cnt),        32'(laps_ovw.size()));
        chk("ow_full",   {31'd0, b_full},   {31'd0, (laps_ovw.size() == DEPTH)});
        chk("ow_ovf",    {31'd0, b_ovf},    32'd0);
        chk("ow_rd",     32'(b_rd),         32'(e_rd_ovw));
    endtask

    task automatic step(input logic r, input logic run, input logic stp, input logic clr,
                        input logic lap, input logic [TW-1:0] t, input logic [1:0] idx);
        rst = r; i_run = run; i_stop = stp; i_clear = clr; i_lap = lap;
        i_time = t; i_rd_idx = idx;
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    typedef struct {
        logic r, run, stp, clr, lap;
        logic [TW-1:0] t;
        logic [1:0] idx;
        logic e_run, e_freeze, e_clear;
        int e_cnt, e_hold, e_rd;
    } vec_t;

    vec_t vecs[19];

    initial begin
        //           r  run stp clr lap  t    idx  run frz clr cnt hold  rd
        vecs[0]  = '{1, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0, 0,   0};
        vecs[1]  = '{0, 1, 0, 0, 0, 0,   0,   1, 0, 0, 0, 0,   0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0,   0,   1, 0, 0, 0, 0,   0};
        vecs[3]  = '{0, 0, 1, 0, 0, 0,   0,   0, 0, 0, 0, 0,   0};
        vecs[4]  = '{0, 0, 0, 1, 0, 0,   0,   0, 0, 1, 0, 0,   0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0, 0,   0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0, 0,   0};
        vecs[7]  = '{0, 1, 0, 0, 0, 0,   0,   1, 0, 0, 0, 0,   0};
        vecs[8]  = '{0, 0, 0, 0, 1, 100, 0,   1, 1, 0, 1, 100, 0};
        vecs[9]  = '{0, 0, 0, 0, 1, 250, 0,   1, 1, 0, 2, 250, 100};
        vecs[10] = '{0, 0, 0, 0, 0, 0,   0,   1, 1, 0, 2, 250, 100};
        vecs[11] = '{0, 0, 0, 0, 0, 0,   1,   1, 1, 0, 2, 250, 250};
        vecs[12] = '{0, 0, 0, 0, 0, 0,   2,   1, 1, 0, 2, 250, 0};
        vecs[13] = '{0, 1, 0, 0, 0, 0,   0,   1, 0, 0, 2, 250, 100};
        vecs[14] = '{0, 0, 1, 0, 0, 0,   0,   0, 0, 0, 2, 250, 100};
        vecs[15] = '{0, 1, 0, 1, 0, 0,   1,   1, 0, 0, 2, 250, 250};
        vecs[16] = '{0, 0, 1, 0, 1, 777, 0,   0, 0, 0, 2, 250, 100};
        vecs[17] = '{0, 0, 0, 1, 0, 0,   0,   0, 0, 1, 0, 0,   100};
        vecs[18] = '{0, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0, 0,   0};

        #2;
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].r, vecs[i].run, vecs[i].stp, vecs[i].clr, vecs[i].lap,
                 vecs[i].t, vecs[i].idx);
            chk("vec_run",    {31'd0, a_run},    {31'd0, vecs[i].e_run});
            chk("vec_freeze", {31'd0, a_freeze}, {31'd0, vecs[i].e_freeze});
            chk("vec_clear",  {31'd0, a_clear},  {31'd0, vecs[i].e_clear});
            chk("vec_cnt",    32'(a_cnt),        32'(vecs[i].e_cnt));
            chk("vec_hold",   32'(a_hold),       32'(vecs[i].e_hold));
            chk("vec_rd",     32'(a_rd),         32'(vecs[i].e_rd));
            chk("vec_ow_rd",  32'(b_rd),         32'(vecs[i].e_rd));
        end

        // Fill past capacity: drop policy keeps 1..4, overwrite policy keeps 3..6.
        step(0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) step(0, 0, 0, 0, 1, TW'(k), 0);
        chk("fill_cnt",  32'(a_cnt), 32'd4);
        chk("fill_full", {31'd0, a_full}, 32'd1);
        chk("fill_ovf",  {31'd0, a_ovf}, 32'd1);
        chk("fill_hold", 32'(a_hold), 32'd5);
        step(0, 0, 0, 0, 1, TW'(6), 0);
        chk("ow_fill_cnt", 32'(b_cnt), 32'd4);
        chk("ow_fill_ovf", {31'd0, b_ovf}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 0, 2'(k));
            chk("drop_entry", 32'(a_rd), 32'(k + 1));
            chk("ow_entry",   32'(b_rd), 32'(k + 3));
        end
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("clr_cnt", 32'(a_cnt), 32'd0);
        chk("clr_ovf", {31'd0, a_ovf}, 32'd0);
        chk("clr_pulse", {31'd0, a_clear}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("clr_pulse_end", {31'd0, a_clear}, 32'd0);

        // SPLIT with run and lap together resumes without a capture.
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, TW'(7), 0);
        step(0, 1, 0, 0, 1, TW'(9), 0);
        chk("resume_freeze", {31'd0, a_freeze}, 32'd0);
        chk("resume_run",    {31'd0, a_run}, 32'd1);
        chk("resume_cnt",    32'(a_cnt), 32'd1);
        chk("resume_hold",   32'(a_hold), 32'd7);

        // Reset in SPLIT with three laps stored.
        step(0, 0, 0, 0, 1, TW'(11), 0);
        step(0, 0, 0, 0, 1, TW'(12), 0);
        chk("pre_rst_cnt", 32'(a_cnt), 32'd3);
        step(1, 0, 0, 0, 1, TW'(13), 0);
        chk("rst_run",    {31'd0, a_run}, 32'd0);
        chk("rst_freeze", {31'd0, a_freeze}, 32'd0);
        chk("rst_cnt",    32'(a_cnt), 32'd0);
        chk("rst_hold",   32'(a_hold), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_rd", 32'(a_rd), 32'd0);

        // Randomised commands against the model.
        for (int n = 0; n < 4000; n++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
                 TW'($urandom), 2'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
